// File: rtl/mem_defs_pkg.sv
// Shared encodings for the memory-stage access unit: load/store types,
// bus transfer sizes, FSM states, and small decode helpers.
package mem_defs_pkg;

   typedef enum logic [2:0] {
      LD_LW  = 3'b000,
      LD_LH  = 3'b001,
      LD_LHU = 3'b010,
      LD_LB  = 3'b011,
      LD_LBU = 3'b100
   } loadType_e;

   typedef enum logic [1:0] {
      ST_SW = 2'b00,
      ST_SH = 2'b01,
      ST_SB = 2'b10
   } storeType_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } dataSize_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } memState_e;

   // Transfer size implied by a load type; unknown encodings fall back to byte.
   function automatic dataSize_e loadSize(input logic [2:0] loadType);
      case (loadType)
         LD_LW:         return SIZE_WORD;
         LD_LH, LD_LHU: return SIZE_HALF;
         default:       return SIZE_BYTE;
      endcase
   endfunction

   // Transfer size implied by a store type; unknown encodings fall back to byte.
   function automatic dataSize_e storeSize(input logic [1:0] storeType);
      case (storeType)
         ST_SW:   return SIZE_WORD;
         ST_SH:   return SIZE_HALF;
         default: return SIZE_BYTE;
      endcase
   endfunction

   // Natural alignment: words on 4-byte, halves on 2-byte boundaries.
   function automatic logic isAligned(input dataSize_e size, input logic [1:0] addrLo);
      case (size)
         SIZE_WORD: return (addrLo == 2'b00);
         SIZE_HALF: return ~addrLo[0];
         default:   return 1'b1;
      endcase
   endfunction

   // Replicate store data across all byte lanes so the slave can pick any lane.
   function automatic logic [31:0] laneReplicate(input logic [1:0] storeType,
                                                 input logic [31:0] wdata);
      case (storeType)
         ST_SB:   return {4{wdata[7:0]}};
         ST_SH:   return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half from a bus word and sign- or zero-extends
// it according to the load type. Purely combinational.
module load_extend
   import mem_defs_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addrLo,
   input  logic [2:0]  loadType,
   output logic [31:0] result
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Lane selection followed by extension by load type.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path; a missing default infers a latch.
      result  = word;
      byteSel = word[{addrLo, 3'b000} +: 8];
      halfSel = addrLo[1] ? word[31:16] : word[15:0];
      case (loadType)
         LD_LH:   result = {{16{halfSel[15]}}, halfSel};
         LD_LHU:  result = {16'h0000, halfSel};
         LD_LB:   result = {{24{byteSel[7]}}, byteSel};
         LD_LBU:  result = {24'h000000, byteSel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns one load/store in M into a single
// req/addr_ok/data_ok bus transaction, checks alignment, extends load data
// and stalls the pipeline until the transaction has completed.
module mem_access_unit
   import mem_defs_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          memreadM,
   input  logic          memwriteM,
   input  logic [2:0]    memread_conM,
   input  logic [1:0]    memwrite_conM,
   input  logic [AW-1:0] addrM,
   input  logic [31:0]   wdataM,
   input  logic          flushM,
   input  logic          advanceM,
   output logic          stallM,
   output logic [31:0]   rdataM,
   output logic          adel,
   output logic          ades,
   output logic [AW-1:0] bad_addr,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [31:0]   data_wdata,
   input  logic [31:0]   data_rdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok
);

   memState_e     state;
   logic          isLoad;
   logic          isStore;
   logic          aligned;
   logic          go;
   dataSize_e     opSize;

   // Copies of the issuing op, held while the bus transaction is in flight.
   logic [AW-1:0] addrLat;
   logic [31:0]   wdataLat;
   dataSize_e     sizeLat;
   logic          wrLat;
   logic [2:0]    loadTypeLat;
   logic          flushedLat;
   logic [31:0]   rdataReg;
   logic [31:0]   extended;

   // Decode the M-stage op and check its alignment; a load wins if both are set.
   always_comb begin
      isLoad   = memreadM;
      isStore  = memwriteM & ~memreadM;
      opSize   = isLoad ? loadSize(memread_conM) : storeSize(memwrite_conM);
      aligned  = isAligned(opSize, addrM[1:0]);
      adel     = isLoad  & ~aligned;
      ades     = isStore & ~aligned;
      bad_addr = addrM;
      go       = (isLoad | isStore) & aligned & ~flushM & (state == S_IDLE);
   end

   // Bus side: live op fields while idle, latched copies once issued.
   always_comb begin
      if (state == S_IDLE) begin
         data_addr  = addrM;
         data_size  = opSize;
         data_wr    = isStore;
         data_wdata = laneReplicate(memwrite_conM, wdataM);
      end else begin
         data_addr  = addrLat;
         data_size  = sizeLat;
         data_wr    = wrLat;
         data_wdata = wdataLat;
      end
      data_req = go | (state == S_REQ);
      stallM   = go | (state == S_REQ) | (state == S_WAIT);
   end

   load_extend uLoadExtend (
      .word     (data_rdata),
      .addrLo   (addrLat[1:0]),
      .loadType (loadTypeLat),
      .result   (extended)
   );

   // Transaction FSM with the op latches and the load result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         addrLat     <= '0;
         wdataLat    <= '0;
         sizeLat     <= SIZE_BYTE;
         wrLat       <= 1'b0;
         loadTypeLat <= '0;
         flushedLat  <= 1'b0;
         rdataReg    <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
         if (go) begin
            addrLat     <= addrM;
            wdataLat    <= laneReplicate(memwrite_conM, wdataM);
            sizeLat     <= opSize;
            wrLat       <= isStore;
            loadTypeLat <= memread_conM;
            flushedLat  <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (go) state <= data_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
               if (flushM) flushedLat <= 1'b1;
               if (data_addr_ok) state <= S_WAIT;
            end
            S_WAIT: begin
               if (flushM) flushedLat <= 1'b1;
               if (data_data_ok) begin
                  // A flushed transaction still completes on the bus, but its result is dropped.
                  if (flushedLat | flushM) begin
                     state <= S_IDLE;
                  end else begin
                     state <= S_DONE;
                     if (!wrLat) rdataReg <= extended;
                  end
               end
            end
            S_DONE: begin
               if (advanceM | flushM) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rdataM = rdataReg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. The bench plays the bus slave; inputs
// change on the falling edge and outputs are sampled 1 ns later.
module tb_mem_access_unit;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          memreadM, memwriteM, flushM, advanceM;
   logic [2:0]    memread_conM;
   logic [1:0]    memwrite_conM;
   logic [AW-1:0] addrM;
   logic [31:0]   wdataM;
   logic          stallM, adel, ades;
   logic [31:0]   rdataM;
   logic [AW-1:0] bad_addr;
   logic          data_req, data_wr;
   logic [1:0]    data_size;
   logic [AW-1:0] data_addr;
   logic [31:0]   data_wdata, data_rdata;
   logic          data_addr_ok, data_data_ok;

   int passCount  = 0;
   int checkCount = 0;

   mem_access_unit #(.AW(AW)) dut (
      .clk(clk), .rst(rst),
      .memreadM(memreadM), .memwriteM(memwriteM),
      .memread_conM(memread_conM), .memwrite_conM(memwrite_conM),
      .addrM(addrM), .wdataM(wdataM), .flushM(flushM), .advanceM(advanceM),
      .stallM(stallM), .rdataM(rdataM), .adel(adel), .ades(ades), .bad_addr(bad_addr),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clearInputs();
      memreadM = 0; memwriteM = 0; memread_conM = 3'b000; memwrite_conM = 2'b00;
      addrM = '0; wdataM = '0; flushM = 0; advanceM = 0;
      data_rdata = '0; data_addr_ok = 0; data_data_ok = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clearInputs();
      repeat (2) @(negedge clk);
      #1;
      checkCount++; if (stallM !== 1'b0) $display("FAIL rst_stall got=%0h exp=0", stallM); else passCount++;
      checkCount++; if (data_req !== 1'b0) $display("FAIL rst_req got=%0h exp=0", data_req); else passCount++;
      checkCount++; if (rdataM !== 32'h0) $display("FAIL rst_rdata got=%08h exp=00000000", rdataM); else passCount++;
      checkCount++; if ({adel, ades} !== 2'b00) $display("FAIL rst_addrerr got=%0b exp=00", {adel, ades}); else passCount++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One load: addr_ok with the request, data_ok two cycles later.
   task automatic test_load(input string name, input logic [2:0] ldType, input logic [31:0] addr,
                            input logic [31:0] busWord, input logic [31:0] expData,
                            input logic [1:0] expSize);
      @(negedge clk);
      memreadM = 1; memread_conM = ldType; addrM = addr; data_addr_ok = 1;
      #1;
      checkCount++; if (data_req !== 1'b1) $display("FAIL %s_req got=%0h exp=1", name, data_req); else passCount++;
      checkCount++; if (data_size !== expSize) $display("FAIL %s_size got=%0d exp=%0d", name, data_size, expSize); else passCount++;
      checkCount++; if (data_addr !== addr) $display("FAIL %s_addr got=%08h exp=%08h", name, data_addr, addr); else passCount++;
      checkCount++; if (data_wr !== 1'b0) $display("FAIL %s_wr got=%0h exp=0", name, data_wr); else passCount++;
      checkCount++; if (stallM !== 1'b1) $display("FAIL %s_stall0 got=%0h exp=1", name, stallM); else passCount++;
      @(negedge clk);
      data_addr_ok = 0;
      #1;
      checkCount++; if (data_req !== 1'b0) $display("FAIL %s_req_wait got=%0h exp=0", name, data_req); else passCount++;
      checkCount++; if (stallM !== 1'b1) $display("FAIL %s_stall1 got=%0h exp=1", name, stallM); else passCount++;
      @(negedge clk);
      data_data_ok = 1; data_rdata = busWord;
      #1;
      checkCount++; if (stallM !== 1'b1) $display("FAIL %s_stall2 got=%0h exp=1", name, stallM); else passCount++;
      @(negedge clk);
      data_data_ok = 0; data_rdata = 32'h0;
      #1;
      checkCount++; if (stallM !== 1'b0) $display("FAIL %s_stall_done got=%0h exp=0", name, stallM); else passCount++;
      checkCount++; if (rdataM !== expData) $display("FAIL %s_rdata got=%08h exp=%08h", name, rdataM, expData); else passCount++;
      advanceM = 1;
      @(negedge clk);
      advanceM = 0; memreadM = 0;
   endtask

   // One store: checks bus fields on issue, completion, and that rdataM is untouched.
   task automatic test_store(input string name, input logic [1:0] stType, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] expSize,
                             input logic [31:0] expWdata, input logic [31:0] keptRdata);
      @(negedge clk);
      memwriteM = 1; memwrite_conM = stType; addrM = addr; wdataM = wdata; data_addr_ok = 1;
      #1;
      checkCount++; if (data_req !== 1'b1) $display("FAIL %s_req got=%0h exp=1", name, data_req); else passCount++;
      checkCount++; if (data_wr !== 1'b1) $display("FAIL %s_wr got=%0h exp=1", name, data_wr); else passCount++;
      checkCount++; if (data_size !== expSize) $display("FAIL %s_size got=%0d exp=%0d", name, data_size, expSize); else passCount++;
      checkCount++; if (data_wdata !== expWdata) $display("FAIL %s_wdata got=%08h exp=%08h", name, data_wdata, expWdata); else passCount++;
      checkCount++; if (data_addr !== addr) $display("FAIL %s_addr got=%08h exp=%08h", name, data_addr, addr); else passCount++;
      @(negedge clk);
      data_addr_ok = 0;
      @(negedge clk);
      data_data_ok = 1; data_rdata = 32'h5555_5555;
      #1;
      checkCount++; if (stallM !== 1'b1) $display("FAIL %s_stall got=%0h exp=1", name, stallM); else passCount++;
      @(negedge clk);
      data_data_ok = 0; data_rdata = 32'h0;
      #1;
      checkCount++; if (stallM !== 1'b0) $display("FAIL %s_stall_done got=%0h exp=0", name, stallM); else passCount++;
      checkCount++; if (rdataM !== keptRdata) $display("FAIL %s_rdata_kept got=%08h exp=%08h", name, rdataM, keptRdata); else passCount++;
      advanceM = 1;
      @(negedge clk);
      advanceM = 0; memwriteM = 0;
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      memwriteM = 1; memwrite_conM = 2'b00; addrM = 32'h1000_0002; data_addr_ok = 1;
      #1;
      checkCount++; if (ades !== 1'b1) $display("FAIL sw_mis_ades got=%0h exp=1", ades); else passCount++;
      checkCount++; if (adel !== 1'b0) $display("FAIL sw_mis_adel got=%0h exp=0", adel); else passCount++;
      checkCount++; if (bad_addr !== 32'h1000_0002) $display("FAIL sw_mis_badaddr got=%08h exp=10000002", bad_addr); else passCount++;
      checkCount++; if (data_req !== 1'b0) $display("FAIL sw_mis_req got=%0h exp=0", data_req); else passCount++;
      checkCount++; if (stallM !== 1'b0) $display("FAIL sw_mis_stall got=%0h exp=0", stallM); else passCount++;
      @(negedge clk);
      memwriteM = 0; memreadM = 1; memread_conM = 3'b001; addrM = 32'h1000_0001;
      #1;
      checkCount++; if (adel !== 1'b1) $display("FAIL lh_mis_adel got=%0h exp=1", adel); else passCount++;
      checkCount++; if (ades !== 1'b0) $display("FAIL lh_mis_ades got=%0h exp=0", ades); else passCount++;
      checkCount++; if (bad_addr !== 32'h1000_0001) $display("FAIL lh_mis_badaddr got=%08h exp=10000001", bad_addr); else passCount++;
      checkCount++; if (data_req !== 1'b0) $display("FAIL lh_mis_req got=%0h exp=0", data_req); else passCount++;
      checkCount++; if (stallM !== 1'b0) $display("FAIL lh_mis_stall got=%0h exp=0", stallM); else passCount++;
      @(negedge clk);
      memreadM = 0; data_addr_ok = 0;
   endtask

   // addr_ok withheld for three cycles with a flush pulse while the request is held.
   task automatic test_held_flush();
      @(negedge clk);
      memwriteM = 1; memwrite_conM = 2'b00; addrM = 32'h1000_0010; wdataM = 32'hCAFE_F00D; data_addr_ok = 0;
      #1;
      checkCount++; if (data_req !== 1'b1) $display("FAIL held_req0 got=%0h exp=1", data_req); else passCount++;
      checkCount++; if (stallM !== 1'b1) $display("FAIL held_stall0 got=%0h exp=1", stallM); else passCount++;
      @(negedge clk);
      addrM = 32'h2000_0000; wdataM = 32'h0; flushM = 1;
      #1;
      checkCount++; if (data_req !== 1'b1) $display("FAIL held_req1 got=%0h exp=1", data_req); else passCount++;
      checkCount++; if (stallM !== 1'b1) $display("FAIL held_stall1 got=%0h exp=1", stallM); else passCount++;
      checkCount++; if (data_addr !== 32'h1000_0010) $display("FAIL held_addr1 got=%08h exp=10000010", data_addr); else passCount++;
      checkCount++; if (data_wdata !== 32'hCAFE_F00D) $display("FAIL held_wdata1 got=%08h exp=cafef00d", data_wdata); else passCount++;
      checkCount++; if (data_wr !== 1'b1) $display("FAIL held_wr1 got=%0h exp=1", data_wr); else passCount++;
      @(negedge clk);
      flushM = 0;
      #1;
      checkCount++; if (data_req !== 1'b1) $display("FAIL held_req2 got=%0h exp=1", data_req); else passCount++;
      checkCount++; if (data_addr !== 32'h1000_0010) $display("FAIL held_addr2 got=%08h exp=10000010", data_addr); else passCount++;
      @(negedge clk);
      data_addr_ok = 1;
      #1;
      checkCount++; if (data_req !== 1'b1) $display("FAIL held_req3 got=%0h exp=1", data_req); else passCount++;
      checkCount++; if (data_wdata !== 32'hCAFE_F00D) $display("FAIL held_wdata3 got=%08h exp=cafef00d", data_wdata); else passCount++;
      @(negedge clk);
      data_addr_ok = 0;
      #1;
      checkCount++; if (data_req !== 1'b0) $display("FAIL held_req_wait got=%0h exp=0", data_req); else passCount++;
      checkCount++; if (stallM !== 1'b1) $display("FAIL held_stall_wait got=%0h exp=1", stallM); else passCount++;
      @(negedge clk);
      data_data_ok = 1;
      #1;
      checkCount++; if (stallM !== 1'b1) $display("FAIL held_stall_dok got=%0h exp=1", stallM); else passCount++;
      @(negedge clk);
      data_data_ok = 0; memwriteM = 0;
      #1;
      checkCount++; if (stallM !== 1'b0) $display("FAIL held_stall_end got=%0h exp=0", stallM); else passCount++;
      // A fresh op issuing immediately shows the FSM went to IDLE rather than DONE.
      @(negedge clk);
      memreadM = 1; memread_conM = 3'b000; addrM = 32'h1000_0020; data_addr_ok = 1;
      #1;
      checkCount++; if (data_req !== 1'b1) $display("FAIL postflush_req got=%0h exp=1", data_req); else passCount++;
      @(negedge clk);
      data_addr_ok = 0;
      @(negedge clk);
      data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      data_data_ok = 0; data_rdata = 32'h0;
      #1;
      checkCount++; if (rdataM !== 32'h0BAD_F00D) $display("FAIL postflush_rdata got=%08h exp=0badf00d", rdataM); else passCount++;
      checkCount++; if (stallM !== 1'b0) $display("FAIL postflush_stall got=%0h exp=0", stallM); else passCount++;
      advanceM = 1;
      @(negedge clk);
      advanceM = 0; memreadM = 0;
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      memreadM = 1; memread_conM = 3'b000; addrM = 32'h1000_0030; data_addr_ok = 1;
      @(negedge clk);
      data_addr_ok = 0;
      #1;
      checkCount++; if (stallM !== 1'b1) $display("FAIL rstw_stall_wait got=%0h exp=1", stallM); else passCount++;
      @(negedge clk);
      rst = 0; memreadM = 0;
      #1;
      checkCount++; if (stallM !== 1'b0) $display("FAIL rstw_stall got=%0h exp=0", stallM); else passCount++;
      checkCount++; if (data_req !== 1'b0) $display("FAIL rstw_req got=%0h exp=0", data_req); else passCount++;
      checkCount++; if (rdataM !== 32'h0) $display("FAIL rstw_rdata got=%08h exp=00000000", rdataM); else passCount++;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      data_data_ok = 1; data_rdata = 32'h7777_7777;
      #1;
      checkCount++; if (stallM !== 1'b0) $display("FAIL rstw_stray_stall got=%0h exp=0", stallM); else passCount++;
      @(negedge clk);
      data_data_ok = 0; data_rdata = 32'h0;
      #1;
      checkCount++; if (rdataM !== 32'h0) $display("FAIL rstw_stray_rdata got=%08h exp=00000000", rdataM); else passCount++;
      checkCount++; if (data_req !== 1'b0) $display("FAIL rstw_stray_req got=%0h exp=0", data_req); else passCount++;
      test_load("rstw_lw", 3'b000, 32'h1000_0040, 32'h1357_9BDF, 32'h1357_9BDF, 2'd2);
   endtask

   initial begin
      test_reset();
      test_load("lw",  3'b000, 32'h1000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd2);
      test_load("lb",  3'b011, 32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80, 2'd0);
      test_load("lbu", 3'b100, 32'h1000_0003, 32'h80FF_1234, 32'h0000_0080, 2'd0);
      test_load("lh",  3'b001, 32'h1000_0002, 32'h80FF_1234, 32'hFFFF_80FF, 2'd1);
      test_load("lhu", 3'b010, 32'h1000_0000, 32'h80FF_9234, 32'h0000_9234, 2'd1);
      test_store("sb", 2'b10, 32'h1000_0001, 32'h1234_56AB, 2'd0, 32'hABAB_ABAB, 32'h0000_9234);
      test_store("sh", 2'b01, 32'h1000_0002, 32'h1234_5678, 2'd1, 32'h5678_5678, 32'h0000_9234);
      test_misaligned();
      test_held_flush();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
